// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter, 11-bit frame decoder
// with odd-parity and framing checks, and a first-word-fall-through byte FIFO for the CPU.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                              sys_clock,
   input  logic                              sys_reset,
   input  logic                              ps2_clk,
   input  logic                              ps2_data,
   input  logic                              rd_en,
   output logic [7:0]                        rd_data,
   output logic                              rd_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow,
   output logic                              frame_err,
   input  logic                              clr_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [FW-1:0] FLT_MAX  = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] flt_cnt_q, flt_cnt_d;
   logic          fall_w;

   state_t        state_q;
   logic [2:0]    bit_cnt_q;
   logic [TW-1:0] tmo_q;
   logic          frame_err_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic          par_ok_w;
   logic          push_w;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          full_w, empty_w, pop_w, wr_w;

   // Input conditioning: 2-FF synchronisers, idle-high like the open-collector bus
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         filt_q    <= 1'b1;
         flt_cnt_q <= '0;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= ps2_data;
         dat_s2_q  <= dat_s1_q;
         filt_q    <= filt_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   // The filtered clock follows only after FILTER_LEN consecutive differing samples
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (flt_cnt_q == FLT_MAX) filt_d = clk_s2_q;
         else                      flt_cnt_d = flt_cnt_q + 1'b1;
      end
   end

   assign fall_w   = filt_q && !filt_d;
   assign par_ok_w = ^{shift_q, par_q};
   assign push_w   = fall_w && (state_q == S_STOP) && dat_s2_q && par_ok_w;

   // Frame decoder
   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (state_q == S_IDLE || fall_w) tmo_q <= '0;
         else                             tmo_q <= tmo_q + 1'b1;

         if (state_q != S_IDLE && !fall_w && tmo_q == TMO_MAX) begin
            state_q     <= S_IDLE;
            frame_err_q <= 1'b1;
         end else if (fall_w) begin
            case (state_q)
               S_IDLE: begin
                  if (!dat_s2_q) begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               S_DATA: begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
               end
               S_PARITY: state_q <= S_STOP;
               S_STOP: begin
                  state_q <= S_IDLE;
                  if (!push_w) frame_err_q <= 1'b1;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // Byte assembly, LSB first
   always_ff @(posedge sys_clock) begin
      if (fall_w && state_q == S_DATA)   shift_q <= {dat_s2_q, shift_q[7:1]};
      if (fall_w && state_q == S_PARITY) par_q   <= dat_s2_q;
   end

   // FIFO: a full FIFO still accepts a byte when the head is popped in the same cycle
   assign full_w  = (count_q == CNT_FULL);
   assign empty_w = (count_q == '0);
   assign pop_w   = rd_en && !empty_w;
   assign wr_w    = push_w && (!full_w || pop_w);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (wr_w)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_w) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_w && !pop_w)      count_d = count_q + 1'b1;
      else if (pop_w && !wr_w) count_d = count_q - 1'b1;
      if (clr_err) overflow_d = 1'b0;
      if (push_w && full_w && !pop_w) overflow_d = 1'b1;
   end

   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (wr_w) mem_q[wr_ptr_q] <= shift_q;
   end

   assign rd_data    = empty_w ? 8'h00 : mem_q[rd_ptr_q];
   assign rd_valid   = !empty_w;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo; the PS/2 bit rate and timeout are scaled down to keep runs short.
module tb_ps2_rx_fifo;

   localparam int FLT  = 8;
   localparam int TMO  = 400;
   localparam int DEP  = 16;
   localparam int HALF = 20;

   logic       sys_clock = 1'b0;
   logic       sys_reset = 1'b1;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic       rd_en     = 1'b0;
   logic       clr_err   = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       frame_err;

   int nvec = 0;
   int nerr = 0;
   int cyc_now = 0;
   int last_fall = 0;
   int fe_pulses = 0;
   int fe_hi = 0;
   int fe_cyc = 0;
   logic fe_prev = 1'b0;

   ps2_rx_fifo #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEP)) dut (
      .sys_clock (sys_clock),
      .sys_reset (sys_reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .frame_err (frame_err),
      .clr_err   (clr_err)
   );

   always #5 sys_clock = ~sys_clock;

   always @(posedge sys_clock) cyc_now <= cyc_now + 1;

   always @(negedge sys_clock) begin
      if (frame_err) fe_hi <= fe_hi + 1;
      if (frame_err && !fe_prev) begin
         fe_pulses <= fe_pulses + 1;
         fe_cyc    <= cyc_now;
      end
      fe_prev <= frame_err;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop();
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
   endtask

   // Sends the first nbits bits of a frame; glitch_bit>=0 adds a 3-cycle low pulse in that bit's high phase
   task automatic send(input logic [7:0] b, input bit par_good, input bit stop_v,
                       input int nbits, input int glitch_bit);
      logic [10:0] fr;
      logic        pbit;
      pbit = par_good ? ~^b : ^b;
      fr   = {stop_v, pbit, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         if (i == glitch_bit) begin
            cyc(8);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(HALF - 11);
         end else begin
            cyc(HALF);
         end
         ps2_clk   = 1'b0;
         last_fall = cyc_now;
         cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      cyc(HALF);
   endtask

   initial begin
      int fe0, hi0, delta, wait_n;
      logic all16;

      cyc(4);
      sys_reset = 1'b0;
      cyc(1);
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", rd_data, 8'h00);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ferr", frame_err, 0);

      // Good frame 0x1C then pop
      send(8'h1C, 1, 1, 11, -1);
      chk("t1_valid", rd_valid, 1);
      chk("t1_data", rd_data, 8'h1C);
      chk("t1_count", fifo_count, 1);
      chk("t1_noerr", fe_pulses, 0);
      pop();
      chk("t1_pop_valid", rd_valid, 0);
      chk("t1_pop_data", rd_data, 8'h00);

      // Bad parity, then bad stop bit
      fe0 = fe_pulses;
      hi0 = fe_hi;
      send(8'hF0, 0, 1, 11, -1);
      send(8'h55, 1, 0, 11, -1);
      cyc(2);
      chk("t2_pulses", fe_pulses - fe0, 2);
      chk("t2_hicycles", fe_hi - hi0, 2);
      chk("t2_count", fifo_count, 0);

      // Glitches in idle and mid-frame
      fe0 = fe_pulses;
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(HALF);
      send(8'h5A, 1, 1, 11, 4);
      chk("t3_count", fifo_count, 1);
      chk("t3_data", rd_data, 8'h5A);
      chk("t3_noerr", fe_pulses - fe0, 0);
      pop();

      // Timeout after start + 4 data bits, then recovery
      fe0 = fe_pulses;
      send(8'h0F, 1, 1, 5, -1);
      wait_n = 0;
      while (fe_pulses == fe0 && wait_n < TMO + 100) begin
         cyc(1);
         wait_n++;
      end
      chk("t4_tmo_seen", fe_pulses - fe0, 1);
      delta = fe_cyc - last_fall;
      chk("t4_tmo_window", (delta >= TMO + FLT && delta <= TMO + FLT + 4), 1);
      chk("t4_count", fifo_count, 0);
      cyc(10);
      send(8'h29, 1, 1, 11, -1);
      chk("t4_rx_count", fifo_count, 1);
      chk("t4_rx_data", rd_data, 8'h29);
      pop();

      // Overflow with 17 frames, drain, clear
      for (int i = 1; i <= 17; i++) send(8'(i), 1, 1, 11, -1);
      chk("t5_count_full", fifo_count, 16);
      chk("t5_ovf", overflow, 1);
      for (int i = 1; i <= 16; i++) begin
         chk("t5_drain", rd_data, 32'(i));
         pop();
      end
      chk("t5_empty", rd_valid, 0);
      chk("t5_ovf_held", overflow, 1);
      clr_err = 1'b1;
      cyc(1);
      clr_err = 1'b0;
      chk("t5_clr", overflow, 0);

      // Full FIFO: push coincident with pop
      for (int i = 0; i < 16; i++) send(8'(32'h20 + i), 1, 1, 11, -1);
      chk("t5_refill", fifo_count, 16);
      send(8'h30, 1, 1, 10, -1);
      chk("t5_head_pre", rd_data, 8'h20);
      cyc(HALF);
      ps2_clk = 1'b0;
      all16 = 1'b1;
      for (int i = 0; i < HALF; i++) begin
         rd_en = (i == FLT + 1);
         cyc(1);
         if (fifo_count != 5'd16) all16 = 1'b0;
      end
      rd_en = 1'b0;
      ps2_clk = 1'b1;
      cyc(HALF);
      chk("t5_pp_count", all16, 1);
      chk("t5_pp_ovf", overflow, 0);
      chk("t5_pp_head", rd_data, 8'h21);

      // Reset mid-frame with bytes queued
      send(8'h31, 1, 1, 11, -1);
      chk("t6_ovf_set", overflow, 1);
      for (int i = 0; i < 13; i++) pop();
      chk("t6_count3", fifo_count, 3);
      chk("t6_head", rd_data, 8'h2E);
      send(8'hAA, 1, 1, 6, -1);
      fe0 = fe_pulses;
      sys_reset = 1'b1;
      cyc(1);
      sys_reset = 1'b0;
      chk("t6_rst_valid", rd_valid, 0);
      chk("t6_rst_data", rd_data, 8'h00);
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_ovf", overflow, 0);
      chk("t6_rst_ferr", frame_err, 0);
      cyc(10);
      send(8'h29, 1, 1, 11, -1);
      chk("t6_rx_count", fifo_count, 1);
      chk("t6_rx_data", rd_data, 8'h29);
      chk("t6_noerr", fe_pulses - fe0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
